// File: rtl/knn_topk_sorter_if.sv
// Candidate-in / sorted-out stream bundle for knn_topk_sorter, plus the occupancy count.
// Parameters must match those of the attached sorter instance.
interface knn_topk_sorter_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LABEL_W = 8,
  parameter int unsigned K       = 4
);
  localparam int unsigned CW = $clog2(K + 1);

  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [LABEL_W-1:0] in_label;
  logic               in_last;

  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [LABEL_W-1:0] out_label;
  logic               out_last;

  logic [CW-1:0]      count;

  modport master (
    output in_valid, in_data, in_label, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_label, out_last, count
  );

  modport slave (
    input  in_valid, in_data, in_label, in_last, out_ready,
    output in_ready, out_valid, out_data, out_label, out_last, count
  );
endinterface

// File: rtl/knn_topk_sorter.sv
// K-deep insertion sorter keeping the K best (distance, label) pairs; KNN_SORT_DESC_EN keeps the largest instead of smallest.
// Latency: insert visible 1 cycle after accept; drain is combinational from the slots, one entry per handshake.
// Backpressure: in_ready low for the whole drain; drain outputs hold while out_ready is low.
module knn_topk_sorter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LABEL_W = 8,
  parameter int unsigned K       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  knn_topk_sorter_if.slave sort_if
);
  localparam int unsigned CW = $clog2(K + 1);
  localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic {S_FILL, S_DRAIN} state_t;

`ifdef KNN_SORT_DESC_EN
  localparam logic [DATA_W-1:0] EMPTY_VAL = '0;
  function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return a > b;
  endfunction
`else
  localparam logic [DATA_W-1:0] EMPTY_VAL = '1;
  function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return a < b;
  endfunction
`endif

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  data_q  [K];
  logic [DATA_W-1:0]  data_d  [K];
  logic [LABEL_W-1:0] label_q [K];
  logic [LABEL_W-1:0] label_d [K];
  logic [K-1:0]       occ_q, occ_d;
  logic [CW-1:0]      count_q, count_d;
  logic [IW-1:0]      rd_idx_q, rd_idx_d;
  logic [K-1:0]       beats;
  logic               last_beat;

  // An empty slot loses to any candidate, so an extreme-valued distance is still retained.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      beats[i] = !occ_q[i] || better(sort_if.in_data, data_q[i]);
    end
  end

  assign last_beat = (state_q == S_DRAIN) && (CW'(rd_idx_q) == count_q - CW'(1));

  assign sort_if.in_ready  = (state_q == S_FILL);
  assign sort_if.out_valid = (state_q == S_DRAIN);
  assign sort_if.out_data  = (state_q == S_DRAIN) ? data_q[rd_idx_q]  : '0;
  assign sort_if.out_label = (state_q == S_DRAIN) ? label_q[rd_idx_q] : '0;
  assign sort_if.out_last  = last_beat;
  assign sort_if.count     = count_q;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    label_d  = label_q;
    occ_d    = occ_q;
    count_d  = count_q;
    rd_idx_d = rd_idx_q;

    case (state_q)
      S_FILL: begin
        if (sort_if.in_valid) begin
          if (beats[0]) begin
            data_d[0]  = sort_if.in_data;
            label_d[0] = sort_if.in_label;
            occ_d[0]   = 1'b1;
          end
          // Ripple: a slot takes its predecessor when the candidate beats that predecessor,
          // otherwise the candidate itself when it lands here; ties fall behind existing entries.
          for (int i = 1; i < K; i++) begin
            if (beats[i-1]) begin
              data_d[i]  = data_q[i-1];
              label_d[i] = label_q[i-1];
              occ_d[i]   = occ_q[i-1];
            end else if (beats[i]) begin
              data_d[i]  = sort_if.in_data;
              label_d[i] = sort_if.in_label;
              occ_d[i]   = 1'b1;
            end
          end
          if (count_q != CW'(K)) begin
            count_d = count_q + CW'(1);
          end
          if (sort_if.in_last) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (sort_if.out_ready) begin
          if (last_beat) begin
            for (int i = 0; i < K; i++) begin
              data_d[i]  = EMPTY_VAL;
              label_d[i] = '0;
            end
            occ_d    = '0;
            count_d  = '0;
            rd_idx_d = '0;
            state_d  = S_FILL;
          end else begin
            rd_idx_d = rd_idx_q + IW'(1);
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q  <= S_FILL;
      occ_q    <= '0;
      count_q  <= '0;
      rd_idx_q <= '0;
      for (int i = 0; i < K; i++) begin
        data_q[i]  <= EMPTY_VAL;
        label_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      occ_q    <= occ_d;
      count_q  <= count_d;
      rd_idx_q <= rd_idx_d;
      data_q   <= data_d;
      label_q  <= label_d;
    end
  end
endmodule

// File: doc/knn_topk_sorter.md
Name: knn_topk_sorter

Overview:
- Parametrised K-deep insertion sorter for the kNN accelerator.
- Keeps the K best distances, each with a caller-supplied label such as the training-sample index, from a stream of candidates.
- Sits after the distance calculator and feeds the vote/classify stage.
- On a last-candidate marker it drains the sorted list over a valid/ready stream, then re-arms itself for the next query.

Parameters:
- DATA_W, 32: distance width, unsigned.
- LABEL_W, 8: label width carried alongside each distance.
- K, 4: number of retained entries, 1..64.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous flush; same effect as rst.
- in_valid  input  1  candidate present.
- in_ready  output  1  sorter accepts a candidate this cycle.
- in_data  input  DATA_W  candidate distance.
- in_label  input  LABEL_W  candidate label.
- in_last  input  1  final candidate of the query; qualified by in_valid.
- out_valid  output  1  sorted entry present.
- out_ready  input  1  consumer accepts the entry.
- out_data  output  DATA_W  sorted distance.
- out_label  output  LABEL_W  label of out_data.
- out_last  output  1  final entry of the drain.
- count  output  $clog2(K+1)  number of occupied slots.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset/clr, sampled on the clk rising edge:
  - All slots become empty: data = all ones, label = 0, occupied = 0.
  - count = 0, state = FILL, read index = 0.
  - out_valid = 0, out_last = 0, out_data/out_label = 0.
  - rst and clr both override any other event in the same cycle.
- States: FILL and DRAIN.
- FILL:
  - in_ready = 1, out_valid = 0.
  - An accept occurs when in_valid and in_ready are both 1.
- Insertion, on accept; slots are kept in ascending order, slot0 = best:
  - Slot i takes the input if in_data < slot[i] and (i==0 or in_data >= slot[i-1]).
  - Slot i takes slot[i-1] if in_data < slot[i-1].
  - Otherwise slot i holds its value.
  - Ties are stable: a new value equal to an existing one is placed after it.
  - count increments, saturating at K.
  - When full, a candidate >= slot[K-1] is discarded and all slots are unchanged.
  - Result is visible on count and the internal slots the cycle after the accept.
- FILL to DRAIN: an accept with in_last = 1 inserts that candidate, then enters DRAIN next cycle. count >= 1 is guaranteed at that point.
- DRAIN:
  - in_ready = 0; in_valid is ignored.
  - out_valid = 1, out_data/out_label = slot[rd_idx].
  - out_last = (rd_idx == count-1).
  - On out_valid && out_ready, rd_idx increments.
  - Outputs stay stable while out_ready = 0.
- Drain completion: a handshake with out_last = 1 empties all slots, clears count and rd_idx, and returns to FILL next cycle. No bubble is needed before the next accept.
- Comparisons are unsigned and full DATA_W; there is no arithmetic overflow path.
- Empty slots are never output: the drain length equals count, which is at most K.

Optional Feature:
- Macro KNN_SORT_DESC_EN.
- Defined:
  - Order is descending, keeping the K largest values.
  - All "<" comparisons become ">".
  - Empty-slot value is all zeros.
  - When full, a candidate <= slot[K-1] is discarded.
  - Tie stability is unchanged.
- Undefined: ascending order, K smallest values, as described above.

Test Plan:
- Reset: assert rst 2 cycles -> count=0, in_ready=1, out_valid=0, out_last=0.
- K=4, insert 7/L0, 3/L1, 9/L2, 5/L3, 1/L4 (last) with out_ready=1 -> drain 1/L4, 3/L1, 5/L3, 7/L0; out_last on the 4th beat; 9 discarded; count=4 during the drain; FILL resumes after.
- Ties: insert 5/LA, 5/LB, 2/LC (last) -> drain 2/LC, 5/LA, 5/LB; count=3; out_last on 5/LB.
- Backpressure: during the drain of the 7-3-9-5-1 run, hold out_ready=0 for 3 cycles at beat 2 and drive in_valid=1 -> out_data stays 3 and out_label stays L1; in_ready=0; the candidate is not inserted.
- Flush: assert clr on beat 2 of the drain -> next cycle state FILL, count=0, out_valid=0, in_ready=1; next query 8 (last) drains as a single beat 8 with out_last=1.
- With KNN_SORT_DESC_EN: insert 7, 3, 9, 5, 1 (last) -> drain 9, 7, 5, 3; 1 discarded.
